// File: rtl/controle_polinomio.sv
// rtl/controle_polinomio.sv - Horner-form sequencer for the polynomial datapath (muxes M0/M1/M2, R0/R1/R2, ULA).
// Moore outputs are registered from the next state so they follow the state without a combinational input path.
module controle_polinomio (
  input  logic       clk,
  input  logic       RST,
  input  logic       iniciar,
  input  logic [1:0] grau,
  input  logic       abortar,
  output logic [1:0] M0,
  output logic [1:0] M1,
  output logic [1:0] M2,
  output logic       LX,
  output logic       LH,
  output logic       LS,
  output logic       H,
  output logic       ocupado,
  output logic       pronto,
  output logic       erro,
  output logic [7:0] contagem
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOADX, S_MUL1_EX, S_MUL1_WR, S_ADD1_EX, S_ADD1_WR,
    S_MUL2_EX, S_MUL2_WR, S_ADD2_EX, S_ADD2_WR, S_DONE
  } state_t;

  localparam logic [1:0] SEL_A = 2'd1;
  localparam logic [1:0] SEL_B = 2'd2;
  localparam logic [1:0] SEL_C = 2'd3;

  state_t     r_state;
  logic [1:0] r_grau;

  state_t     w_state_nxt;
  logic [1:0] w_grau_nxt;
  logic       w_erro_nxt;
  logic       w_cnt_inc;
  logic [1:0] w_m0, w_m1, w_m2;
  logic       w_lx, w_lh, w_ls, w_h;

  always_comb begin
    w_state_nxt = r_state;
    w_grau_nxt  = r_grau;
    w_erro_nxt  = 1'b0;
    w_cnt_inc   = 1'b0;
    if (r_state != S_IDLE && abortar) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (iniciar) begin
            if (grau == 2'b01 || grau == 2'b10) begin
              w_state_nxt = S_LOADX;
              w_grau_nxt  = grau;
            end else begin
              w_erro_nxt = 1'b1;
            end
          end
        end
        S_LOADX:   w_state_nxt = S_MUL1_EX;
        S_MUL1_EX: w_state_nxt = S_MUL1_WR;
        S_MUL1_WR: w_state_nxt = (r_grau == 2'b10) ? S_ADD1_EX : S_ADD2_EX;
        S_ADD1_EX: w_state_nxt = S_ADD1_WR;
        S_ADD1_WR: w_state_nxt = S_MUL2_EX;
        S_MUL2_EX: w_state_nxt = S_MUL2_WR;
        S_MUL2_WR: w_state_nxt = S_ADD2_EX;
        S_ADD2_EX: w_state_nxt = S_ADD2_WR;
        S_ADD2_WR: w_state_nxt = S_DONE;
        S_DONE: begin
          w_state_nxt = S_IDLE;
          w_cnt_inc   = 1'b1;
        end
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode of the state being entered; EX and WR share selects, WR adds the load.
  always_comb begin
    w_m0 = 2'd0;
    w_m1 = 2'd0;
    w_m2 = 2'd0;
    w_lx = 1'b0;
    w_lh = 1'b0;
    w_ls = 1'b0;
    w_h  = 1'b0;
    case (w_state_nxt)
      S_LOADX: w_lx = 1'b1;
      S_MUL1_EX, S_MUL1_WR: begin
        w_m0 = (w_grau_nxt == 2'b10) ? SEL_A : SEL_B;
        w_h  = 1'b1;
        w_lh = (w_state_nxt == S_MUL1_WR);
      end
      S_ADD1_EX, S_ADD1_WR: begin
        w_m0 = SEL_B;
        w_m1 = 2'd2;
        w_m2 = 2'd1;
        w_lh = (w_state_nxt == S_ADD1_WR);
      end
      S_MUL2_EX, S_MUL2_WR: begin
        w_m1 = 2'd2;
        w_h  = 1'b1;
        w_lh = (w_state_nxt == S_MUL2_WR);
      end
      S_ADD2_EX, S_ADD2_WR: begin
        w_m0 = SEL_C;
        w_m1 = 2'd2;
        w_m2 = 2'd1;
        w_ls = (w_state_nxt == S_ADD2_WR);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_state  <= S_IDLE;
      r_grau   <= 2'b00;
      M0       <= 2'd0;
      M1       <= 2'd0;
      M2       <= 2'd0;
      LX       <= 1'b0;
      LH       <= 1'b0;
      LS       <= 1'b0;
      H        <= 1'b0;
      ocupado  <= 1'b0;
      pronto   <= 1'b0;
      erro     <= 1'b0;
      contagem <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_grau  <= w_grau_nxt;
      M0      <= w_m0;
      M1      <= w_m1;
      M2      <= w_m2;
      LX      <= w_lx;
      LH      <= w_lh;
      LS      <= w_ls;
      H       <= w_h;
      ocupado <= (w_state_nxt != S_IDLE);
      pronto  <= (w_state_nxt == S_DONE);
      erro    <= w_erro_nxt;
      if (w_cnt_inc) contagem <= contagem + 8'd1;
    end
  end

endmodule

// File: tb/tb_controle_polinomio.sv
// tb/tb_controle_polinomio.sv - directed bench for controle_polinomio with a behavioural datapath beside it.
module tb_controle_polinomio;

  logic       clk, RST, iniciar, abortar;
  logic [1:0] grau;
  logic [1:0] M0, M1, M2;
  logic       LX, LH, LS, H, ocupado, pronto, erro;
  logic [7:0] contagem;

  int total = 0;
  int bad   = 0;

  controle_polinomio dut (
    .clk(clk), .RST(RST), .iniciar(iniciar), .grau(grau), .abortar(abortar),
    .M0(M0), .M1(M1), .M2(M2), .LX(LX), .LH(LH), .LS(LS), .H(H),
    .ocupado(ocupado), .pronto(pronto), .erro(erro), .contagem(contagem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {M0,M1,M2,LX,LH,LS,H,ocupado,pronto,erro}
  logic [12:0] w_obs;
  assign w_obs = {M0, M1, M2, LX, LH, LS, H, ocupado, pronto, erro};

  localparam logic [12:0] V_IDLE    = 13'b0000000000000;
  localparam logic [12:0] V_ERRO    = 13'b0000000000001;
  localparam logic [12:0] V_LOADX   = 13'b0000001000100;
  localparam logic [12:0] V_MUL1A_E = 13'b0100000001100;
  localparam logic [12:0] V_MUL1A_W = 13'b0100000101100;
  localparam logic [12:0] V_MUL1B_E = 13'b1000000001100;
  localparam logic [12:0] V_MUL1B_W = 13'b1000000101100;
  localparam logic [12:0] V_ADD1_E  = 13'b1010010000100;
  localparam logic [12:0] V_ADD1_W  = 13'b1010010100100;
  localparam logic [12:0] V_MUL2_E  = 13'b0010000001100;
  localparam logic [12:0] V_MUL2_W  = 13'b0010000101100;
  localparam logic [12:0] V_ADD2_E  = 13'b1110010000100;
  localparam logic [12:0] V_ADD2_W  = 13'b1110010010100;
  localparam logic [12:0] V_DONE    = 13'b0000000000110;

  // Behavioural datapath driven by the controller outputs.
  int coef_a, coef_b, coef_c, val_x;
  int r0, r1, r2, ula;
  int w_m0out, w_op1, w_op2;
  always_comb begin
    case (M0)
      2'd1:    w_m0out = coef_a;
      2'd2:    w_m0out = coef_b;
      2'd3:    w_m0out = coef_c;
      default: w_m0out = 0;
    endcase
    case (M1)
      2'd0:    w_op1 = w_m0out;
      2'd1:    w_op1 = r0;
      2'd2:    w_op1 = r1;
      default: w_op1 = r2;
    endcase
    case (M2)
      2'd0:    w_op2 = r0;
      2'd1:    w_op2 = w_m0out;
      2'd2:    w_op2 = r1;
      default: w_op2 = r2;
    endcase
  end
  always @(posedge clk) begin
    ula <= H ? w_op1 * w_op2 : w_op1 + w_op2;
    if (LX) r0 <= val_x;
    if (LH) r1 <= ula;
    if (LS) r2 <= ula;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [12:0] exp);
    @(posedge clk);
    @(negedge clk);
    check(tag, {19'd0, w_obs}, {19'd0, exp});
  endtask

  // Accept a start, then scramble grau to prove only the latched value steers the run.
  task automatic start_run(input logic [1:0] g);
    iniciar = 1'b1;
    grau    = g;
    step("loadx", V_LOADX);
    iniciar = 1'b0;
    grau    = (g == 2'b10) ? 2'b01 : 2'b10;
  endtask

  logic [12:0] lin_seq [7];

  initial begin
    lin_seq[0] = V_LOADX;   lin_seq[1] = V_MUL1B_E; lin_seq[2] = V_MUL1B_W;
    lin_seq[3] = V_ADD2_E;  lin_seq[4] = V_ADD2_W;  lin_seq[5] = V_DONE;
    lin_seq[6] = V_IDLE;
    iniciar = 1'b0; abortar = 1'b0; grau = 2'b00;
    coef_a = 2; coef_b = 3; coef_c = 5; val_x = 4;
    r0 = 0; r1 = 0; r2 = 0; ula = 0;
    RST = 1'b1;
    #2 RST = 1'b0;
    @(negedge clk);
    check("reset_outputs", {19'd0, w_obs}, 32'd0);
    check("reset_contagem", {24'd0, contagem}, 32'd0);
    RST = 1'b1;
    step("idle_after_reset", V_IDLE);

    // Quadratic: 2*16 + 3*4 + 5 = 49
    start_run(2'b10);
    step("q_mul1_ex", V_MUL1A_E);
    step("q_mul1_wr", V_MUL1A_W);
    step("q_add1_ex", V_ADD1_E);
    step("q_add1_wr", V_ADD1_W);
    step("q_mul2_ex", V_MUL2_E);
    step("q_mul2_wr", V_MUL2_W);
    step("q_add2_ex", V_ADD2_E);
    step("q_add2_wr", V_ADD2_W);
    step("q_done", V_DONE);
    check("q_r2", r2, 32'd49);
    check("q_cnt_in_done", {24'd0, contagem}, 32'd0);
    step("q_idle", V_IDLE);
    check("q_contagem", {24'd0, contagem}, 32'd1);

    // Linear: 3*4 + 5 = 17
    start_run(2'b01);
    for (int k = 1; k < 7; k++) step("lin_seq", lin_seq[k]);
    check("lin_r2", r2, 32'd17);
    check("lin_contagem", {24'd0, contagem}, 32'd2);

    // Invalid degrees
    iniciar = 1'b1; grau = 2'b00;
    step("erro_grau0", V_ERRO);
    iniciar = 1'b0;
    step("erro_grau0_once", V_IDLE);
    iniciar = 1'b1; grau = 2'b11;
    step("erro_grau3", V_ERRO);
    iniciar = 1'b0;
    step("erro_grau3_once", V_IDLE);
    check("erro_contagem", {24'd0, contagem}, 32'd2);

    // Abort in ADD1_WR, with a coincident iniciar that must lose
    start_run(2'b10);
    step("ab_mul1_ex", V_MUL1A_E);
    step("ab_mul1_wr", V_MUL1A_W);
    step("ab_add1_ex", V_ADD1_E);
    step("ab_add1_wr", V_ADD1_W);
    abortar = 1'b1; iniciar = 1'b1; grau = 2'b10;
    step("ab_idle", V_IDLE);
    abortar = 1'b0; iniciar = 1'b0;
    step("ab_idle2", V_IDLE);
    step("ab_idle3", V_IDLE);
    check("ab_contagem", {24'd0, contagem}, 32'd2);

    // Recovery run: 1*9 + 0*3 + 7 = 16
    coef_a = 1; coef_b = 0; coef_c = 7; val_x = 3;
    start_run(2'b10);
    step("r_mul1_ex", V_MUL1A_E);
    step("r_mul1_wr", V_MUL1A_W);
    step("r_add1_ex", V_ADD1_E);
    step("r_add1_wr", V_ADD1_W);
    step("r_mul2_ex", V_MUL2_E);
    step("r_mul2_wr", V_MUL2_W);
    step("r_add2_ex", V_ADD2_E);
    step("r_add2_wr", V_ADD2_W);
    step("r_done", V_DONE);
    check("r_r2", r2, 32'd16);
    step("r_idle", V_IDLE);
    check("r_contagem", {24'd0, contagem}, 32'd3);

    // Back-to-back linear runs with iniciar held high; contagem passes 255 -> 0
    iniciar = 1'b1; grau = 2'b01;
    for (int run = 0; run < 256; run++) begin
      for (int k = 0; k < 7; k++) begin
        if (run == 255 && k == 6) iniciar = 1'b0;
        step("b2b_seq", lin_seq[k]);
      end
      check("b2b_contagem", {24'd0, contagem}, {24'd0, 8'(4 + run)});
      if (run == 251) check("b2b_cnt_255", {24'd0, contagem}, 32'd255);
      if (run == 252) check("b2b_cnt_wrap", {24'd0, contagem}, 32'd0);
    end
    step("b2b_stopped", V_IDLE);

    // Asynchronous reset in MUL2_EX
    start_run(2'b10);
    step("rst_mul1_ex", V_MUL1A_E);
    step("rst_mul1_wr", V_MUL1A_W);
    step("rst_add1_ex", V_ADD1_E);
    step("rst_add1_wr", V_ADD1_W);
    step("rst_mul2_ex", V_MUL2_E);
    #2 RST = 1'b0;
    #1;
    check("rst_async_outputs", {19'd0, w_obs}, 32'd0);
    check("rst_async_contagem", {24'd0, contagem}, 32'd0);
    @(negedge clk);
    RST = 1'b1;
    step("rst_idle", V_IDLE);
    step("rst_idle2", V_IDLE);
    check("rst_contagem_after", {24'd0, contagem}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/controle_polinomio.md
# controle_polinomio

Sequencing controller for the polynomial datapath (operand muxes M0/M1/M2, registers R0/R1/R2, shared add/multiply ULA). It accepts a start request with a degree selector and drives the mux selects, load enables and ULA operation cycle by cycle. The sequence evaluates y = A·x² + B·x + C (degree 2) or y = B·x + C (degree 1) in Horner form, with the result landing in R2. It sits beside the datapath and presents a start/pronto handshake to the surrounding system.

## Interface
- No parameters; all widths fixed.
- clk  in  1  system clock; all state changes on the rising edge
- RST  in  1  asynchronous, active-low reset (RST=0 resets immediately)
- iniciar  in  1  start request, sampled only in IDLE
- grau  in  2  polynomial degree, latched on accepted start: 2'b01 = linear, 2'b10 = quadratic; 2'b00 and 2'b11 are invalid
- abortar  in  1  synchronous abort, honoured in every state except IDLE
- M0  out  2  coefficient mux select: 1=A, 2=B, 3=C, 0=idle
- M1  out  2  ULA operand-1 select: 0=M0 out, 1=R0, 2=R1, 3=R2
- M2  out  2  ULA operand-2 select: 0=R0, 1=M0 out, 2=R1, 3=R2
- LX  out  1  load R0 with x
- LH  out  1  load R1 with ULA result
- LS  out  1  load R2 with ULA result
- H  out  1  ULA operation: 1 = multiply, 0 = add
- ocupado  out  1  high in every state except IDLE
- pronto  out  1  one-cycle pulse; R2 holds a valid result
- erro  out  1  one-cycle pulse on a start with an invalid grau
- contagem  out  8  count of completed evaluations, wraps 255→0

## Operation
- The ULA result is registered. Each arithmetic step therefore takes two states:
  - EX: selects and H driven.
  - WR: the same selects and H held, plus the load enable.
- States and outputs. Every signal not listed is 0.
  - IDLE: all outputs 0.
  - LOADX: LX=1.
  - MUL1_EX / MUL1_WR: M0 = A if grau=2, B if grau=1; M1=0, M2=0, H=1. LH=1 in WR. Result: R1 = coef·x.
  - ADD1_EX / ADD1_WR: M0=B, M1=2, M2=1, H=0. LH=1 in WR. Result: R1 = A·x + B.
  - MUL2_EX / MUL2_WR: M1=2, M2=0, H=1. LH=1 in WR. Result: R1 = R1·x.
  - ADD2_EX / ADD2_WR: M0=C, M1=2, M2=1, H=0. LS=1 in WR. Result: R2 = R1 + C.
  - DONE: pronto=1.
- Transitions:
  - IDLE → LOADX when iniciar=1 and grau ∈ {1,2}.
  - If iniciar=1 and grau ∈ {0,3}: stay in IDLE and pulse erro for the next cycle.
  - LOADX → MUL1_EX.
  - Each EX state → its WR state.
  - MUL1_WR → ADD1_EX when grau_latched=2, else → ADD2_EX.
  - ADD1_WR → MUL2_EX.
  - MUL2_WR → ADD2_EX.
  - ADD2_WR → DONE.
  - DONE → IDLE; contagem increments on this transition.
- iniciar outside IDLE is ignored; no queuing.
- abortar=1 in any non-IDLE state (including DONE) → IDLE at the next edge:
  - no pronto, no contagem increment;
  - R2 contents are undefined for the system.
- The grau input is ignored after acceptance; only grau_latched steers the sequence.
- Arithmetic width and overflow are the datapath's concern. The controller is width-agnostic.

## Timing
- Reset values: state IDLE, all outputs 0, contagem=0, grau_latched=0.
- Outputs are decoded from the registered state (Moore); there is no combinational path from inputs to outputs.
- Start accepted at edge t0:
  - LOADX in cycle t0+1.
  - Quadratic: ADD2_WR in cycle t0+9, pronto in cycle t0+10.
  - Linear: ADD2_WR in cycle t0+5, pronto in cycle t0+6.
- The earliest next accepted start is the edge ending the first IDLE cycle after DONE, so the back-to-back period is 11 (quadratic) / 7 (linear) cycles.
- If abortar and iniciar are high in the same cycle in a non-IDLE state, abort wins and iniciar is ignored.
- Reset asserted mid-sequence forces IDLE and zeroes all outputs immediately, without waiting for clk.

## Test plan
- Reset: hold RST=0 mid-sequence (e.g. in MUL2_EX) → all outputs 0 at once; after release, the controller is in IDLE with contagem=0.
- Quadratic: A=2, B=3, C=5, x=4, grau=2, one-cycle iniciar → select/load sequence exactly as listed; pronto pulse 10 cycles after the start edge; R2=49; contagem=1.
- Linear: B=3, C=5, x=4, grau=1 → states MUL1 then ADD2 only; M0=B in MUL1; pronto at +6; R2=17.
- Invalid degree: grau=0, then grau=3, each with iniciar → erro pulses once per start, ocupado stays 0, no LX.
- Abort: abortar=1 in ADD1_WR of a quadratic run → IDLE next cycle, no pronto, contagem unchanged; a following valid run completes normally.
- Back-to-back and wrap: iniciar held high continuously with grau=1 → a new run every 7 cycles and iniciar ignored while ocupado; after 256 runs contagem wraps to 0.
